// File: rtl/vga_pixel_fetch.sv
// Framebuffer prefetch for the VGA output: streams words in raster order into a
// small FIFO and emits one pixel per enabled cycle, keeping pixel alignment across stalls.
module vga_pixel_fetch #(
  parameter int                FB_X_MAX     = 1280,
  parameter int                FB_Y_MAX     = 1024,
  parameter int                ADDR_W       = 21,
  parameter int                DATA_W       = 8,
  parameter int                DEPTH        = 16,
  parameter logic [DATA_W-1:0] UNDERRUN_PIX = '0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     frame_start,
  input  logic                     enable,
  output logic                     rd_req,
  output logic [ADDR_W-1:0]        rd_addr,
  input  logic                     rd_gnt,
  input  logic                     rd_valid,
  input  logic [DATA_W-1:0]        rd_data,
  output logic [DATA_W-1:0]        pix_data,
  output logic                     pix_valid,
  output logic                     underrun,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  localparam int CW = ADDR_W + 1;
  localparam logic [CW-1:0]     TOTAL     = CW'(FB_X_MAX * FB_Y_MAX);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FB_X_MAX * FB_Y_MAX - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FETCH = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  logic [1:0]        state;
  logic [LW-1:0]     wr_ptr;
  logic [LW-1:0]     rd_ptr;
  logic [LW-1:0]     inflight;
  logic [LW-1:0]     inflight_next;
  logic [CW-1:0]     drop;
  logic [CW-1:0]     drop_next;
  logic [CW-1:0]     issued;
  logic [DATA_W-1:0] mem [DEPTH];

  logic [LW:0] room_used;
  logic        accept;
  logic        empty;
  logic        do_pop;
  logic        starve;
  logic        ret_drop;
  logic        ret_live;
  logic        push;

  assign level     = wr_ptr - rd_ptr;
  // Words already requested count against FIFO space, so a push can never overflow.
  assign room_used = {1'b0, level} + {1'b0, inflight};
  assign rd_req    = (state == FETCH) && (room_used < (LW+1)'(DEPTH));
  assign accept    = rd_req & rd_gnt;

  assign empty    = (level == '0);
  assign do_pop   = enable & ~empty;
  assign starve   = enable & empty;
  assign ret_drop = rd_valid & (drop != '0);
  assign ret_live = rd_valid & (drop == '0);
  // A live word arriving during an underrun is the one that slot owed, so it is discarded.
  assign push     = ret_live & ~starve & ~frame_start;

  assign inflight_next = inflight + LW'(accept) - LW'(rd_valid);

  always_comb begin
    drop_next = drop;
    if (ret_drop && !starve) begin
      drop_next = drop - 1'b1;
    end else if (starve && !rd_valid && (drop != '1)) begin
      // Saturate: once this many words are owed every outstanding return is discarded anyway.
      drop_next = drop + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      rd_addr   <= '0;
      issued    <= '0;
      inflight  <= '0;
      drop      <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      pix_data  <= '0;
      pix_valid <= 1'b0;
      underrun  <= 1'b0;
    end else begin
      inflight  <= inflight_next;
      pix_valid <= enable;
      if (do_pop) begin
        pix_data <= mem[rd_ptr[PW-1:0]];
      end else if (starve) begin
        pix_data <= UNDERRUN_PIX;
        underrun <= 1'b1;
      end

      if (frame_start) begin
        // Every read still outstanding belongs to the old frame.
        state   <= FETCH;
        wr_ptr  <= '0;
        rd_ptr  <= '0;
        rd_addr <= '0;
        issued  <= '0;
        drop    <= CW'(inflight_next);
      end else begin
        drop <= drop_next;
        if (push) begin
          wr_ptr <= wr_ptr + 1'b1;
        end
        if (do_pop) begin
          rd_ptr <= rd_ptr + 1'b1;
        end
        if (accept) begin
          issued <= issued + 1'b1;
          if (rd_addr != LAST_ADDR) begin
            rd_addr <= rd_addr + 1'b1;
          end
          if (issued == TOTAL - 1'b1) begin
            state <= DONE;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr[PW-1:0]] <= rd_data;
    end
  end

endmodule

// File: tb/tb_vga_pixel_fetch.sv
// Bench for vga_pixel_fetch: in-order memory with random latency, a slot-based
// pixel model (slot k shows word k if it arrived before that cycle) and directed scenarios.
module tb_vga_pixel_fetch;

  localparam int FBX   = 4;
  localparam int FBY   = 2;
  localparam int TOTAL = FBX * FBY;
  localparam int AW    = 3;
  localparam int DW    = 8;
  localparam int DEPTH = 4;
  localparam int LW    = 3;
  localparam logic [DW-1:0] UPIX = 8'hFF;

  logic          clk = 1'b0;
  logic          rst;
  logic          frame_start;
  logic          enable;
  logic          rd_req;
  logic [AW-1:0] rd_addr;
  logic          rd_gnt;
  logic          rd_valid;
  logic [DW-1:0] rd_data;
  logic [DW-1:0] pix_data;
  logic          pix_valid;
  logic          underrun;
  logic [LW-1:0] level;

  vga_pixel_fetch #(
    .FB_X_MAX(FBX), .FB_Y_MAX(FBY), .ADDR_W(AW), .DATA_W(DW),
    .DEPTH(DEPTH), .UNDERRUN_PIX(UPIX)
  ) dut (
    .clk(clk), .rst(rst), .frame_start(frame_start), .enable(enable),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt), .rd_valid(rd_valid),
    .rd_data(rd_data), .pix_data(pix_data), .pix_valid(pix_valid),
    .underrun(underrun), .level(level)
  );

  always #5 clk = ~clk;

  typedef struct {
    int           due;
    int           tag;
    int           addr;
    logic [DW-1:0] data;
  } req_t;

  req_t memq[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   cur_tag = 0;
  int   frame_count = 0;
  int   issued_m = 0;
  int   slot = 0;
  int   lat_min = 1;
  int   lat_max = 1;
  int   ret_prob = 100;
  bit   hold = 1'b0;
  bit   fetching = 1'b0;
  bit   ret_m [TOTAL];
  logic [DW-1:0] ret_d [TOTAL];
  logic [DW-1:0] exp_pix;
  bit   exp_pv;
  bit   exp_ur;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Words of the current frame that arrived and are not yet shown or skipped.
  function automatic int exp_level();
    int n = 0;
    for (int i = slot; i < TOTAL; i++) if (ret_m[i]) n++;
    return n;
  endfunction

  function automatic bit exp_req();
    return fetching && (issued_m < TOTAL) && (exp_level() + memq.size() < DEPTH);
  endfunction

  function automatic int exp_addr();
    return (issued_m < TOTAL) ? issued_m : TOTAL - 1;
  endfunction

  task automatic model_reset();
    memq.delete();
    fetching = 1'b0;
    issued_m = 0;
    slot     = 0;
    for (int i = 0; i < TOTAL; i++) ret_m[i] = 1'b0;
    exp_pix = '0;
    exp_pv  = 1'b0;
    exp_ur  = 1'b0;
  endtask

  task automatic compare();
    chk("pix_data", 32'(pix_data), 32'(exp_pix));
    chk("pix_valid", 32'(pix_valid), 32'(exp_pv));
    chk("underrun", 32'(underrun), 32'(exp_ur));
    chk("level", 32'(level), exp_level());
    chk("rd_req", 32'(rd_req), 32'(exp_req()));
    chk("rd_addr", 32'(rd_addr), exp_addr());
    chk("occupancy bound", 32'(int'(level) + memq.size() <= DEPTH), 32'd1);
  endtask

  // Drive one cycle of inputs, advance the model over the edge, then compare.
  task automatic cycle(input bit f, input bit e, input bit g);
    bit   acc;
    req_t r;
    if (f) begin
      e = 1'b0;
      g = 1'b0;
    end
    frame_start = f;
    enable      = e;
    rd_gnt      = g;
    rd_valid    = 1'b0;
    rd_data     = 8'($urandom);
    if (memq.size() > 0 && !hold && memq[0].due <= cyc &&
        $urandom_range(0, 99) < ret_prob) begin
      rd_valid = 1'b1;
      rd_data  = memq[0].data;
    end

    acc = exp_req() && g;
    if (e) begin
      if (slot < TOTAL && ret_m[slot]) begin
        exp_pix = ret_d[slot];
      end else begin
        exp_pix = UPIX;
        exp_ur  = 1'b1;
      end
      slot++;
    end
    exp_pv = e;
    if (rd_valid) begin
      r = memq.pop_front();
      if (!f && r.tag == cur_tag) begin
        ret_m[r.addr] = 1'b1;
        ret_d[r.addr] = r.data;
      end
    end
    if (acc) begin
      r.due  = cyc + int'($urandom_range(lat_min, lat_max));
      r.tag  = cur_tag;
      r.addr = issued_m;
      r.data = 8'(cur_tag * 16 + issued_m);
      memq.push_back(r);
      issued_m++;
    end
    if (f) begin
      cur_tag = frame_count;
      frame_count++;
      issued_m = 0;
      slot     = 0;
      fetching = 1'b1;
      for (int i = 0; i < TOTAL; i++) ret_m[i] = 1'b0;
    end

    @(posedge clk);
    cyc++;
    @(negedge clk);
    compare();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got cycle %0d, expected completion", cyc);
    $fatal(1);
  end

  initial begin
    int ep;
    int gp;
    rst = 1'b1; frame_start = 1'b0; enable = 1'b0; rd_gnt = 1'b0;
    rd_valid = 1'b0; rd_data = '0;
    model_reset();
    repeat (2) @(negedge clk);
    compare();
    rst = 1'b0;

    // Fast memory, frame of 8 words shown after a 20-cycle gap.
    lat_min = 1; lat_max = 1; ret_prob = 100;
    cycle(1'b1, 1'b0, 1'b0);
    repeat (20) cycle(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) begin
      cycle(1'b0, 1'b1, 1'b1);
      chk("t1 pixel", 32'(pix_data), i);
    end
    chk("t1 underrun", 32'(underrun), 32'd0);
    chk("t1 rd_req done", 32'(rd_req), 32'd0);
    chk("t1 rd_addr last", 32'(rd_addr), 32'd7);
    chk("t1 accepts", issued_m, 32'd8);

    // Grant withheld: three underruns, then word 3 is the first shown.
    cycle(1'b1, 1'b0, 1'b0);
    repeat (3) cycle(1'b0, 1'b0, 1'b0);
    chk("t2 rd_req held", 32'(rd_req), 32'd1);
    chk("t2 rd_addr held", 32'(rd_addr), 32'd0);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b1, 1'b0);
      chk("t2 underrun pixel", 32'(pix_data), 32'hFF);
    end
    chk("t2 underrun flag", 32'(underrun), 32'd1);
    repeat (12) cycle(1'b0, 1'b0, 1'b1);
    cycle(1'b0, 1'b1, 1'b1);
    chk("t2 first real pixel", 32'(pix_data), 32'h13);

    // Long latency with sparse enables; the per-cycle bound check does the work.
    lat_min = 30; lat_max = 30;
    cycle(1'b1, 1'b0, 1'b0);
    repeat (300) cycle(1'b0, $urandom_range(0, 99) < 30, $urandom_range(0, 99) < 80);
    repeat (40) cycle(1'b0, 1'b0, 1'b0);

    // Restart with reads in flight and words queued.
    lat_min = 8; lat_max = 8;
    cycle(1'b1, 1'b0, 1'b0);
    repeat (10) cycle(1'b0, 1'b0, 1'b1);
    chk("t4 level before restart", 32'(level), 32'd2);
    chk("t4 inflight before restart", memq.size(), 32'd2);
    cycle(1'b1, 1'b0, 1'b0);
    chk("t4 level after restart", 32'(level), 32'd0);
    repeat (30) cycle(1'b0, 1'b0, 1'b1);
    cycle(1'b0, 1'b1, 1'b1);
    chk("t4 first pixel", 32'(pix_data), 32'h40);

    // Asynchronous reset in the middle of a frame.
    lat_min = 2; lat_max = 5;
    cycle(1'b1, 1'b0, 1'b0);
    repeat (6) cycle(1'b0, 1'b1, 1'b1);
    frame_start = 1'b0; enable = 1'b0; rd_gnt = 1'b0; rd_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("t6 pix_data reset", 32'(pix_data), 32'd0);
    chk("t6 pix_valid reset", 32'(pix_valid), 32'd0);
    chk("t6 underrun reset", 32'(underrun), 32'd0);
    chk("t6 level reset", 32'(level), 32'd0);
    chk("t6 rd_req reset", 32'(rd_req), 32'd0);
    chk("t6 rd_addr reset", 32'(rd_addr), 32'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    compare();
    repeat (5) cycle(1'b0, 1'b0, 1'b1);
    chk("t6 rd_req idle", 32'(rd_req), 32'd0);

    // Underrun coinciding with the return of word 2.
    lat_min = 1; lat_max = 1; hold = 1'b1;
    cycle(1'b1, 1'b0, 1'b0);
    repeat (8) cycle(1'b0, 1'b0, 1'b1);
    hold = 1'b0;
    cycle(1'b0, 1'b0, 1'b1);
    cycle(1'b0, 1'b1, 1'b1);
    chk("t5 word 0", 32'(pix_data), 32'h60);
    hold = 1'b1;
    cycle(1'b0, 1'b1, 1'b1);
    chk("t5 word 1", 32'(pix_data), 32'h61);
    chk("t5 no underrun yet", 32'(underrun), 32'd0);
    hold = 1'b0;
    cycle(1'b0, 1'b1, 1'b1);
    chk("t5 underrun pixel", 32'(pix_data), 32'hFF);
    chk("t5 underrun flag", 32'(underrun), 32'd1);
    cycle(1'b0, 1'b0, 1'b1);
    cycle(1'b0, 1'b1, 1'b1);
    chk("t5 word 3", 32'(pix_data), 32'h63);

    // Randomized traffic across many frames.
    for (int s = 0; s < 40; s++) begin
      lat_min  = int'($urandom_range(1, 6));
      lat_max  = lat_min + int'($urandom_range(0, 10));
      ret_prob = int'($urandom_range(40, 100));
      ep       = int'($urandom_range(10, 90));
      gp       = int'($urandom_range(20, 100));
      if ($urandom_range(0, 3) != 0) cycle(1'b1, 1'b0, 1'b0);
      repeat ($urandom_range(40, 120))
        cycle($urandom_range(0, 199) == 0, $urandom_range(0, 99) < ep,
              $urandom_range(0, 99) < gp);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
